// File: rtl/quad_encoder_multi.sv
// quad_encoder_multi: multi-channel quadrature decoder.
// Each channel synchronises its raw A/B pins, glitch-filters them, decodes
// Gray-code steps at x4/x2/x1 resolution and keeps a wrapping or saturating
// up/down coordinate. Channels share nothing but the clock and reset.
//
// Handshake: none. Inputs are level-sampled every clock; step is a one-cycle
// pulse registered alongside coordinate, with no back-pressure.
module quad_encoder_multi #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int MODE        = 0,
  parameter int SATURATE    = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       encoder_a,
  input  logic [CHANNELS-1:0]       encoder_b,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS*WIDTH-1:0] coordinate,
  output logic [CHANNELS-1:0]       step,
  output logic [CHANNELS-1:0]       direction,
  output logic [CHANNELS-1:0]       error
);

  // Samples needed after reset before the filter holds only real pin data
  // (the synchroniser and filter both start out full of reset zeros).
  localparam int WARM = SYNC_STAGES + FILTER_LEN;
  localparam int CW   = $clog2(WARM + 1);

  genvar n;
  generate
    for (n = 0; n < CHANNELS; n++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_a;
      logic [SYNC_STAGES-1:0] sync_b;
      logic [1:0]             filt [FILTER_LEN];
      logic [1:0]             f;
      logic                   primed;
      logic [CW-1:0]          warm_cnt;
      logic [WIDTH-1:0]       coord;
      logic                   step_q;
      logic                   dir_q;
      logic                   err_q;

      logic                   warm;
      logic                   stable;
      logic                   load;
      logic                   decode;
      logic                   fwd;
      logic                   rev;
      logic                   illegal;
      logic                   a_changed;
      logic                   counted;
      logic [WIDTH-1:0]       next_coord;

      // Filter acceptance, Gray-code decode and next coordinate value.
      always_comb begin
        stable = 1'b1;
        for (int i = 1; i < FILTER_LEN; i++) begin
          if (filt[i] != filt[0]) stable = 1'b0;
        end
        warm   = (warm_cnt == CW'(WARM));
        // Before priming, the first stable value is taken as-is so that an
        // encoder resting at any phase is not mistaken for a transition.
        load   = warm && stable && (!primed || (filt[0] != f));
        decode = load && primed;

        fwd = decode && (((f == 2'b00) && (filt[0] == 2'b10)) ||
                         ((f == 2'b10) && (filt[0] == 2'b11)) ||
                         ((f == 2'b11) && (filt[0] == 2'b01)) ||
                         ((f == 2'b01) && (filt[0] == 2'b00)));
        rev = decode && (((f == 2'b10) && (filt[0] == 2'b00)) ||
                         ((f == 2'b11) && (filt[0] == 2'b10)) ||
                         ((f == 2'b01) && (filt[0] == 2'b11)) ||
                         ((f == 2'b00) && (filt[0] == 2'b01)));
        illegal   = decode && ((f ^ filt[0]) == 2'b11);
        a_changed = (f[1] != filt[0][1]);

        case (MODE)
          1:       counted = (fwd || rev) && a_changed;
          2:       counted = (fwd && (f == 2'b00)) || (rev && (f == 2'b10));
          default: counted = fwd || rev;
        endcase

        next_coord = coord;
        if (fwd) begin
          if (!((SATURATE != 0) && (coord == {WIDTH{1'b1}})))
            next_coord = coord + WIDTH'(1);
        end else if (rev) begin
          if (!((SATURATE != 0) && (coord == '0)))
            next_coord = coord - WIDTH'(1);
        end
      end

      // Synchroniser, filter, primed state, coordinate and flags.
      always_ff @(posedge clock) begin
        if (reset) begin
          sync_a   <= '0;
          sync_b   <= '0;
          for (int i = 0; i < FILTER_LEN; i++) filt[i] <= 2'b00;
          f        <= 2'b00;
          primed   <= 1'b0;
          warm_cnt <= '0;
          coord    <= '0;
          step_q   <= 1'b0;
          dir_q    <= 1'b0;
          err_q    <= 1'b0;
        end else begin
          sync_a  <= {sync_a[SYNC_STAGES-2:0], encoder_a[n]};
          sync_b  <= {sync_b[SYNC_STAGES-2:0], encoder_b[n]};
          filt[0] <= {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
          for (int i = 1; i < FILTER_LEN; i++) filt[i] <= filt[i-1];
          if (!warm) warm_cnt <= warm_cnt + CW'(1);
          if (load) begin
            f      <= filt[0];
            primed <= 1'b1;
          end
          step_q <= counted;
          if (counted) begin
            dir_q <= fwd;
            coord <= next_coord;
          end
          if (illegal) err_q <= 1'b1;
          // Clear overrides a same-edge step or illegal transition.
          if (clear[n]) begin
            coord <= '0;
            err_q <= 1'b0;
          end
        end
      end

      assign coordinate[n*WIDTH +: WIDTH] = coord;
      assign step[n]      = step_q;
      assign direction[n] = dir_q;
      assign error[n]     = err_q;
    end
  endgenerate

endmodule
